// File: rtl/avg_pkg.sv
// Shared types for the moving-average sequencer and its running-sum datapath.
package avg_pkg;

    localparam int WIN_LOG2  = 6;
    localparam int WIN_DEPTH = 1 << WIN_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FILL,
        RUN
    } sched_state_t;

    // Control bundle handed to the RAM-based running-sum averager.
    typedef struct packed {
        logic                sample_stb;
        logic [WIN_LOG2-1:0] wr_addr;
        logic                sub_old_en;
        logic                sum_clear;
    } avg_ctrl_t;

endpackage

// File: rtl/phase_edge_detect.sv
// Watches the selected phase bit and flags each toggle; the baseline is
// re-captured on load and rebase so the first reported edge is always real.
module phase_edge_detect #(
    parameter int PHASE_W = 32,
    parameter int RATE_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    input  logic [RATE_W-1:0]  sample_rate,
    input  logic               load,
    input  logic               rebase,
    input  logic               track,
    output logic               rate_changed,
    output logic               tog
);

    logic [RATE_W-1:0] rate_q;
    logic              prev_bit;
    logic              cur_bit;
    logic              new_bit;

    // Out-of-range indices fall back to bit 0.
    function automatic logic pick_bit(input logic [PHASE_W-1:0] vec,
                                      input logic [RATE_W-1:0]  idx);
        logic [PHASE_W-1:0] mask;
        if (int'(idx) < PHASE_W) begin
            mask = PHASE_W'(1) << idx;
        end else begin
            mask = PHASE_W'(1);
        end
        return |(vec & mask);
    endfunction

    assign cur_bit      = pick_bit(phase, rate_q);
    assign new_bit      = pick_bit(phase, sample_rate);
    assign rate_changed = (sample_rate != rate_q);
    assign tog          = track & (cur_bit ^ prev_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q   <= '0;
            prev_bit <= 1'b0;
        end else if (load) begin
            rate_q   <= sample_rate;
            prev_bit <= new_bit;
        end else if (rebase || track) begin
            prev_bit <= cur_bit;
        end
    end

endmodule

// File: rtl/avg_sample_scheduler.sv
// Sequencer for the 64-sample moving average: derives the sample strobe from
// the NCO phase and drives buffer address, running-sum control and fill tracking.
module avg_sample_scheduler
    import avg_pkg::*;
#(
    parameter int WIN_LOG2 = avg_pkg::WIN_LOG2,
    parameter int PHASE_W  = 32,
    parameter int RATE_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  phase,
    input  logic [RATE_W-1:0]   sample_rate,
    output logic                sample_stb,
    output logic [WIN_LOG2-1:0] wr_addr,
    output logic                sub_old_en,
    output logic                sum_clear,
    output logic [WIN_LOG2:0]   fill_count,
    output logic                window_full,
    output logic                avg_valid
);

    localparam logic [WIN_LOG2:0] FULL_COUNT = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] LAST_COUNT = FULL_COUNT - 1'b1;

    sched_state_t        state_q;
    sched_state_t        state_d;
    logic                load;
    logic                rebase;
    logic                track;
    logic                tog;
    logic                rate_changed;
    logic                stb_q;
    logic                clr_q;
    logic                avg_q;
    logic [WIN_LOG2-1:0] addr_q;
    logic [WIN_LOG2-1:0] addr_d;
    logic [WIN_LOG2:0]   fill_q;
    logic [WIN_LOG2:0]   fill_d;
    logic                full;
    avg_ctrl_t           ctrl;

    phase_edge_detect #(
        .PHASE_W (PHASE_W),
        .RATE_W  (RATE_W)
    ) u_edge (
        .clk          (clk),
        .rst          (rst),
        .phase        (phase),
        .sample_rate  (sample_rate),
        .load         (load),
        .rebase       (rebase),
        .track        (track),
        .rate_changed (rate_changed),
        .tog          (tog)
    );

    // Disable beats a rate change, which beats a toggle; a suppressed toggle
    // simply never reaches the strobe register because track stays low.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rebase  = 1'b0;
        track   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    load    = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (rate_changed) begin
                    load = 1'b1;
                end else begin
                    rebase  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL, RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (rate_changed) begin
                    load    = 1'b1;
                    state_d = ARM;
                end else begin
                    track = 1'b1;
                    if (state_q == FILL && stb_q && fill_q == LAST_COUNT) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        fill_d = fill_q;
        if (!enable || state_q == ARM) begin
            addr_d = '0;
            fill_d = '0;
        end else if (stb_q) begin
            addr_d = addr_q + 1'b1;
            if (fill_q != FULL_COUNT) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            clr_q   <= 1'b0;
            avg_q   <= 1'b0;
            addr_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= tog;
            clr_q   <= load;
            avg_q   <= stb_q & full;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
        end
    end

    assign full = (fill_q == FULL_COUNT);

    // The oldest slot only holds a real sample once the window has filled.
    always_comb begin
        ctrl            = '0;
        ctrl.sample_stb = stb_q;
        ctrl.wr_addr    = addr_q;
        ctrl.sub_old_en = stb_q & full;
        ctrl.sum_clear  = clr_q;
    end

    assign sample_stb  = ctrl.sample_stb;
    assign wr_addr     = ctrl.wr_addr;
    assign sub_old_en  = ctrl.sub_old_en;
    assign sum_clear   = ctrl.sum_clear;
    assign fill_count  = fill_q;
    assign window_full = full;
    assign avg_valid   = avg_q;

endmodule
